// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: data-cache request/response handshake, store lane
// alignment, load extraction/extension, misalignment detection and pipeline stall.
module mem_stage_lsu #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic                    i_mem_access,
  input  logic                    i_mem_we,
  input  logic [2:0]              i_func3,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_write_data,
  input  logic [3:0]              i_cause,
  output logic                    o_dc_req_valid,
  input  logic                    i_dc_req_ready,
  output logic [ADDR_WIDTH-1:0]   o_dc_addr,
  output logic                    o_dc_we,
  output logic [DATA_WIDTH-1:0]   o_dc_wdata,
  output logic [DATA_WIDTH/8-1:0] o_dc_be,
  input  logic                    i_dc_resp_valid,
  input  logic [DATA_WIDTH-1:0]   i_dc_rdata,
  output logic [DATA_WIDTH-1:0]   o_read_data,
  output logic                    o_stall_mem,
  output logic                    o_misaligned,
  output logic [3:0]              o_cause
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic [2:0]              off_q, off_d;
  logic [2:0]              func3_q, func3_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [2:0]              off;
  logic                    misaligned;
  logic                    idle;
  logic                    fault;
  logic                    start;
  logic [BE_W-1:0]         base_be;
  logic [BE_W-1:0]         req_be;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [ADDR_WIDTH-1:0]   req_addr;

  // Shift the addressed lane down, then extend according to access size/sign.
  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] rd,
                                                     input logic [2:0] lane,
                                                     input logic [2:0] f3);
    logic [DATA_WIDTH-1:0] r;
    r = rd >> {lane, 3'b000};
    case (f3)
      3'b000:  load_ext = {{56{r[7]}}, r[7:0]};
      3'b001:  load_ext = {{48{r[15]}}, r[15:0]};
      3'b010:  load_ext = {{32{r[31]}}, r[31:0]};
      3'b100:  load_ext = {56'd0, r[7:0]};
      3'b101:  load_ext = {48'd0, r[15:0]};
      3'b110:  load_ext = {32'd0, r[31:0]};
      default: load_ext = r;
    endcase
  endfunction

  always_comb begin
    off = i_addr[2:0];
    case (i_func3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      2'b11:   misaligned = |off;
      default: misaligned = 1'b0;
    endcase
    case (i_func3[1:0])
      2'b00:   base_be = 8'h01;
      2'b01:   base_be = 8'h03;
      2'b10:   base_be = 8'h0F;
      default: base_be = 8'hFF;
    endcase
    idle      = (state_q == ST_IDLE);
    fault     = idle & i_mem_access & misaligned;
    start     = idle & i_mem_access & ~misaligned & (i_cause == 4'd0);
    req_be    = base_be << off;
    req_wdata = i_write_data << {off, 3'b000};
    req_addr  = {i_addr[ADDR_WIDTH-1:3], 3'b000};
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    off_d   = off_q;
    func3_d = func3_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = req_addr;
          we_d    = i_mem_we;
          wdata_d = req_wdata;
          be_d    = req_be;
          off_d   = off;
          func3_d = i_func3;
          if (i_dc_req_ready) state_d = i_mem_we ? ST_DONE : ST_WAIT;
          else                state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_dc_req_ready) state_d = we_q ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (i_dc_resp_valid) begin
          rdata_d = load_ext(i_dc_rdata, off_q, func3_q);
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields come straight from the inputs in the start cycle, from the
  // latched copy while retrying, and are zeroed whenever no request is shown.
  always_comb begin
    o_dc_req_valid = start | (state_q == ST_REQ);
    o_dc_addr      = '0;
    o_dc_we        = 1'b0;
    o_dc_wdata     = '0;
    o_dc_be        = '0;
    if (start) begin
      o_dc_addr  = req_addr;
      o_dc_we    = i_mem_we;
      o_dc_wdata = req_wdata;
      o_dc_be    = req_be;
    end else if (state_q == ST_REQ) begin
      o_dc_addr  = addr_q;
      o_dc_we    = we_q;
      o_dc_wdata = wdata_q;
      o_dc_be    = be_q;
    end
    o_stall_mem  = start | (state_q == ST_REQ) | (state_q == ST_WAIT);
    o_misaligned = fault;
    o_cause      = fault ? (i_mem_we ? 4'd6 : 4'd4) : i_cause;
    o_read_data  = rdata_q;
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      func3_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      func3_q <= func3_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
